// File: rtl/mantissa_divsqrt_if.sv
// Request/result bundle between the FP divide/sqrt control and the mantissa datapath.
// The master issues start/op/operands; the slave (the datapath) returns status and the result.
interface mantissa_divsqrt_if #(
  parameter int MWIDTH = 24
);
  logic              start;
  logic [1:0]        op;
  logic [MWIDTH-1:0] m1;
  logic [MWIDTH-1:0] m2;
  logic              shift;
  logic              busy;
  logic              done;
  logic [MWIDTH-1:0] q;
  logic              decrement;
  logic              sticky;
  logic              err;

  modport master (
    output start, op, m1, m2, shift,
    input  busy, done, q, decrement, sticky, err
  );

  modport slave (
    input  start, op, m1, m2, shift,
    output busy, done, q, decrement, sticky, err
  );
endinterface

// File: rtl/mantissa_divsqrt.sv
// Iterative radix-2 restoring mantissa divider / square-rooter, one result bit per cycle.
// Optional MANT_DIVSQRT_EARLY_EXIT_EN: finish as soon as the remaining result bits are known zero.
module mantissa_divsqrt #(
  parameter int MWIDTH = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  mantissa_divsqrt_if.slave bus
);
  localparam int RW = MWIDTH + 3;       // partial remainder width
  localparam int NW = 2 * MWIDTH + 2;   // radicand bits fed two per sqrt step
  localparam int CW = $clog2(MWIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q;
  logic              op_sqrt_q;
  logic              err_pend_q;
  logic [MWIDTH-1:0] b_q;
  logic [RW-1:0]     rem_q;
  logic [NW-1:0]     n_q;
  logic [MWIDTH:0]   qr_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q, dec_q, sticky_q, err_q;
  logic [MWIDTH-1:0] res_q;

  logic              illegal;
  logic              step_ge;
  logic [RW-1:0]     rem_d;
  logic [NW-1:0]     n_d;
  logic [MWIDTH:0]   qr_d;
  logic [RW+1:0]     sq_cur;
  logic [RW+1:0]     sq_trial;

  assign illegal  = bus.op[1] | (~bus.op[0] & ~bus.m2[MWIDTH-1]);
  assign sq_cur   = {rem_q, n_q[NW-1 -: 2]};
  assign sq_trial = {2'b00, qr_q, 2'b01};

  // One restoring step; the sqrt difference always fits RW bits, so it is taken modulo 2^RW.
  always_comb begin
    step_ge = 1'b0;
    rem_d   = '0;
    n_d     = n_q << 2;
    if (op_sqrt_q) begin
      step_ge = (sq_cur >= sq_trial);
      rem_d   = step_ge ? (sq_cur[RW-1:0] - sq_trial[RW-1:0]) : sq_cur[RW-1:0];
    end else begin
      step_ge = (rem_q >= {3'b000, b_q});
      rem_d   = step_ge ? ((rem_q - {3'b000, b_q}) << 1) : (rem_q << 1);
    end
    qr_d = {qr_q[MWIDTH-1:0], step_ge};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_sqrt_q  <= 1'b0;
      err_pend_q <= 1'b0;
      b_q        <= '0;
      rem_q      <= '0;
      n_q        <= '0;
      qr_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= '0;
      dec_q      <= 1'b0;
      sticky_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            op_sqrt_q  <= ~bus.op[1] & bus.op[0];
            err_pend_q <= illegal;
            b_q        <= bus.m2;
            qr_q       <= '0;
            cnt_q      <= illegal ? '0 : CW'(MWIDTH + 1);
            rem_q      <= bus.op[0] ? '0 : {3'b000, bus.m1};
            n_q        <= bus.shift ? {bus.m1, 1'b0, {(MWIDTH+1){1'b0}}}
                                    : {1'b0, bus.m1, {(MWIDTH+1){1'b0}}};
            res_q      <= '0;
            dec_q      <= 1'b0;
            sticky_q   <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            rem_q <= rem_d;
            n_q   <= n_d;
            qr_q  <= qr_d;
`ifdef MANT_DIVSQRT_EARLY_EXIT_EN
            // sqrt may only stop once the unconsumed radicand bits are zero as well
            if (rem_d == '0 && (!op_sqrt_q || n_d == '0)) begin
              qr_q  <= qr_d << (cnt_q - 1'b1);
              cnt_q <= '0;
            end
`endif
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (err_pend_q) begin
              res_q    <= '0;
              dec_q    <= 1'b0;
              sticky_q <= 1'b0;
              err_q    <= 1'b1;
            end else if (!op_sqrt_q && !qr_q[MWIDTH]) begin
              res_q    <= qr_q[MWIDTH-1:0];
              dec_q    <= 1'b1;
              sticky_q <= |rem_q;
            end else begin
              res_q    <= qr_q[MWIDTH:1];
              dec_q    <= 1'b0;
              sticky_q <= qr_q[0] | (|rem_q);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.q         = res_q;
  assign bus.decrement = dec_q;
  assign bus.sticky    = sticky_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mantissa_divsqrt.sv
// Scoreboard bench for mantissa_divsqrt: expected results are queued at acceptance and
// compared when done pulses; directed cases use fixed constants, random ones an integer model.
module tb_mantissa_divsqrt;
  localparam int W = 24;

  typedef struct {
    logic [W-1:0] q;
    logic         dec;
    logic         sticky;
    logic         err;
    int           t0;
    int           lat;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  mantissa_divsqrt_if #(.MWIDTH(W)) bus ();

  mantissa_divsqrt #(.MWIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: exact integer division / integer square root by binary search.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] m1,
                                 input logic [W-1:0] m2, input logic sh);
    exp_t   e;
    longint n, r, qr, x, lo, hi, mid;
    logic [63:0] qv;
    e.q = '0; e.dec = 1'b0; e.sticky = 1'b0; e.err = 1'b0; e.t0 = 0;
    if (op[1] || (op == 2'b00 && !m2[W-1])) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    e.lat = W + 2;
    if (op == 2'b00) begin
      n  = longint'(m1) << W;
      qr = n / longint'(m2);
      r  = n % longint'(m2);
      qv = qr;
      if (qv[W]) begin
        e.q = qv[W:1]; e.sticky = qv[0] | (r != 0);
      end else begin
        e.q = qv[W-1:0]; e.dec = 1'b1; e.sticky = (r != 0);
      end
    end else begin
      x  = sh ? (longint'(m1) << 1) : longint'(m1);
      n  = x << (W + 1);
      lo = 0;
      hi = longint'(1) << (W + 2);
      while (lo < hi) begin
        mid = (lo + hi + 1) / 2;
        if (mid * mid <= n) lo = mid;
        else hi = mid - 1;
      end
      r  = n - lo * lo;
      qv = lo;
      e.q = qv[W:1]; e.sticky = qv[0] | (r != 0);
    end
    return e;
  endfunction

  // Drive one start for a cycle; queue the expectation only if the DUT will accept it.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] m1, input logic [W-1:0] m2,
                       input logic sh, input exp_t e);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.m1 = m1; bus.m2 = m2; bus.shift = sh;
    if (!bus.busy && !bus.done) begin
      e.t0 = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.m1 = $urandom; bus.m2 = $urandom; bus.op = 2'($urandom); bus.shift = 1'($urandom);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.busy || bus.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 64'(sb.size()), 64'd0);
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic dec, input logic st,
                              input logic er, input int lat);
    exp_t e;
    e.q = q; e.dec = dec; e.sticky = st; e.err = er; e.t0 = 0; e.lat = lat;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        check_val("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("op done cycle=%0d q=0x%06h dec=%b sticky=%b err=%b", cyc, bus.q,
                 bus.decrement, bus.sticky, bus.err);
        check_val("q", 64'(bus.q), 64'(e.q));
        check_val("decrement", 64'(bus.decrement), 64'(e.dec));
        check_val("sticky", 64'(bus.sticky), 64'(e.sticky));
        check_val("err", 64'(bus.err), 64'(e.err));
        check_val("busy_at_done", 64'(bus.busy), 64'd0);
`ifndef MANT_DIVSQRT_EARLY_EXIT_EN
        check_val("latency", 64'(cyc - e.t0), 64'(e.lat));
`endif
      end
    end
  end

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] rm1, rm2;
    logic         rsh;
    cyc = 0; checks = 0; errors = 0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.m1 = '0; bus.m2 = '0; bus.shift = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_busy", 64'(bus.busy), 64'd0);
    check_val("reset_done", 64'(bus.done), 64'd0);
    check_val("reset_q", 64'(bus.q), 64'd0);
    check_val("reset_flags", 64'({bus.decrement, bus.sticky, bus.err}), 64'd0);
    reset_n = 1'b1;

    // Directed cases with fixed expected values
    issue(2'b00, 24'h800000, 24'h800000, 1'b0, mk(24'h800000, 1'b0, 1'b0, 1'b0, W + 2));
    check_val("busy_after_start", 64'(bus.busy), 64'd1);
    drain("drain_div_1_1");
    issue(2'b00, 24'h800000, 24'hC00000, 1'b0, mk(24'hAAAAAA, 1'b1, 1'b1, 1'b0, W + 2));
    drain("drain_div_1_1p5");
    issue(2'b01, 24'h800000, 24'h000000, 1'b1, mk(24'hB504F3, 1'b0, 1'b1, 1'b0, W + 2));
    drain("drain_sqrt2");
    issue(2'b01, 24'h800000, 24'h123456, 1'b0, mk(24'h800000, 1'b0, 1'b0, 1'b0, W + 2));
    drain("drain_sqrt1");
    issue(2'b10, 24'h800000, 24'h800000, 1'b0, mk(24'h000000, 1'b0, 1'b0, 1'b1, 1));
    drain("drain_illegal");
    issue(2'b00, 24'hFFFFFF, 24'h7FFFFF, 1'b0, mk(24'h000000, 1'b0, 1'b0, 1'b1, 1));
    drain("drain_zero_div");
    issue(2'b00, 24'hFFFFFF, 24'h800000, 1'b0, model(2'b00, 24'hFFFFFF, 24'h800000, 1'b0));
    drain("drain_div_max");
    issue(2'b01, 24'hFFFFFF, 24'h0, 1'b1, model(2'b01, 24'hFFFFFF, 24'h0, 1'b1));
    drain("drain_sqrt_max");

    // start held high with random operands: only starts seen while idle complete
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rop = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      rm1 = W'($urandom) | 24'h800000;
      rm2 = ($urandom_range(0, 7) == 0) ? (W'($urandom) & 24'h7FFFFF) : (W'($urandom) | 24'h800000);
      rsh = 1'($urandom);
      bus.start = 1'b1; bus.op = rop; bus.m1 = rm1; bus.m2 = rm2; bus.shift = rsh;
      if (!bus.busy && !bus.done) begin
        exp_t e;
        e = model(rop, rm1, rm2, rsh);
        e.t0 = cyc + 1;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    drain("drain_random");

    // Asynchronous reset in the middle of a divide
    issue(2'b00, 24'h800000, 24'hC00000, 1'b0, mk(24'hAAAAAA, 1'b1, 1'b1, 1'b0, W + 2));
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_done", 64'(bus.done), 64'd0);
    check_val("abort_outputs", 64'({bus.q, bus.decrement, bus.sticky, bus.err}), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    issue(2'b00, 24'hC00000, 24'h800000, 1'b0, model(2'b00, 24'hC00000, 24'h800000, 1'b0));
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
